// File: rtl/xor_mismatch_acc_pkg.sv
// Shared types and helpers for the XOR mismatch accumulator.
// State encoding and popcount result width.
package xor_mismatch_acc_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int pc_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/xor_mismatch_acc_popcount.sv
// Combinational population count of a WIDTH-bit word.
// Result width is clog2(WIDTH+1) so an all-ones word fits.
module popcount
  import xor_mismatch_acc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]        in,
  output logic [pc_w(WIDTH)-1:0]  cnt
);

  localparam int PW = pc_w(WIDTH);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + PW'(in[i]);
    end
  end

endmodule

// File: rtl/xor_mismatch_acc.sv
// Burst mismatch accumulator: sums popcount, words and zero words
// of an XOR stream, then holds the totals until handshaken.
module xor_mismatch_acc
  import xor_mismatch_acc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 24,
  parameter int WC_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] f,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] total_ones,
  output logic [WC_W-1:0]  word_count,
  output logic [WC_W-1:0]  zero_words,
  output logic             overflow,
  output logic             busy
);

  localparam int PW = pc_w(WIDTH);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;

  state_t r_state;
  state_t w_next;

  logic          r_v1;
  logic [PW-1:0] r_pc1;
  logic          r_z1;

  logic [CNT_W-1:0] r_ones;
  logic [WC_W-1:0]  r_wc;
  logic [WC_W-1:0]  r_zw;
  logic             r_ovf;

  logic          w_accept;
  logic          w_start;
  logic [PW-1:0] w_pc;
  logic [SW-1:0] w_ones_sum;
  logic          w_ones_ovf;
  logic          w_wc_ovf;
  logic          w_zw_ovf;

  popcount #(.WIDTH(WIDTH)) u_pc (
    .in  (f),
    .cnt (w_pc)
  );

  assign w_accept = in_valid & in_ready;
  assign w_start  = start & (r_state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start)               w_next = S_ACCUM;
      S_ACCUM: if (w_accept && in_last) w_next = S_DRAIN;
      S_DRAIN: if (!r_v1)               w_next = S_DONE;
      S_DONE:  if (out_ready)           w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_ACCUM);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_pc1 <= '0;
      r_z1  <= 1'b0;
    end else if (w_accept) begin
      r_v1  <= 1'b1;
      r_pc1 <= w_pc;
      r_z1  <= (f == '0);
    end else begin
      r_v1  <= 1'b0;
    end
  end

  // Saturation is detected on widened sums so no carry is lost.
  assign w_ones_sum = SW'(r_ones) + SW'(r_pc1);
  assign w_ones_ovf = |w_ones_sum[SW-1:CNT_W];
  assign w_wc_ovf   = &r_wc;
  assign w_zw_ovf   = r_z1 & (&r_zw);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ones <= '0;
      r_wc   <= '0;
      r_zw   <= '0;
      r_ovf  <= 1'b0;
    end else if (w_start) begin
      r_ones <= '0;
      r_wc   <= '0;
      r_zw   <= '0;
      r_ovf  <= 1'b0;
    end else if (r_v1) begin
      r_ones <= w_ones_ovf ? '1 : w_ones_sum[CNT_W-1:0];
      if (!w_wc_ovf)
        r_wc <= r_wc + WC_W'(1);
      if (r_z1 && !w_zw_ovf)
        r_zw <= r_zw + WC_W'(1);
      r_ovf  <= r_ovf | w_ones_ovf | w_wc_ovf | w_zw_ovf;
    end
  end

  assign total_ones = r_ones;
  assign word_count = r_wc;
  assign zero_words = r_zw;
  assign overflow   = r_ovf;

endmodule
